// File: rtl/ringbuf_reader_pkg.sv
// Skid occupancy encoding for the ring buffer drain stage.
package ringbuf_reader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/ringbuf.sv
// One-hot pointer ring buffer; pop clears the slot and has no underflow guard.
// Writes are dropped while full; o_data is the head slot, valid while o_empty=0.
module ringbuf #(
  parameter int WIDTH = 4,
  parameter int SIZE  = 20
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int CW = $clog2(SIZE + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(SIZE);

  logic [SIZE-1:0]  head;
  logic [SIZE-1:0]  tail;
  logic [WIDTH-1:0] mem [SIZE];
  logic [CW-1:0]    cnt;
  logic             wr;

  assign wr      = i_we && !o_full;
  assign o_empty = (cnt == '0);
  assign o_full  = (cnt == FULL_CNT);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (head[i]) o_data = o_data | mem[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head <= SIZE'(1);
      tail <= SIZE'(1);
      cnt  <= '0;
      for (int i = 0; i < SIZE; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < SIZE; i++) begin
        if (wr && tail[i])        mem[i] <= i_wdata;
        else if (i_re && head[i]) mem[i] <= '0;
      end
      if (wr)   tail <= {tail[SIZE-2:0], tail[SIZE-1]};
      if (i_re) head <= {head[SIZE-2:0], head[SIZE-1]};
      case ({wr, i_re})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ringbuf_reader.sv
// Ring buffer drain into a 2-entry skid; pop visible on o_valid one cycle later.
// Pop never depends on i_ready: the skid absorbs stalls and stops popping when full.
import ringbuf_reader_pkg::*;

module ringbuf_reader #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_rb_data,
  input  logic             i_rb_empty,
  output logic             o_rb_re,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count
);

  skid_state_t      state;
  skid_state_t      state_nxt;
  logic [WIDTH-1:0] entry1;
  logic             pop;
  logic             deq;

  // Gating with i_rst_n keeps the ring buffer head untouched while reset is held.
  assign pop     = i_rst_n && !i_rb_empty && (state != TWO) && !i_flush;
  assign o_rb_re = pop;
  assign o_valid = (state != EMPTY);
  assign deq     = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (pop) state_nxt = ONE;
        ONE: begin
          if (pop && !deq)      state_nxt = TWO;
          else if (deq && !pop) state_nxt = EMPTY;
        end
        TWO:     if (deq) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      entry1  <= '0;
      o_count <= '0;
    end else begin
      if (pop && (state == EMPTY || (state == ONE && deq))) o_data <= i_rb_data;
      else if (deq && state == TWO)                        o_data <= entry1;
      if (pop && state == ONE && !deq) entry1 <= i_rb_data;
      if (deq) o_count <= o_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ringbuf_reader.sv
// Ring buffer + drain stage bench: scoreboard of written words, monitor checks each cycle.
module tb_ringbuf_reader;

  localparam int W    = 4;
  localparam int SIZE = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         ready = 1'b0;
  logic         flush = 1'b0;

  logic [W-1:0] rb_data, o_data, o_data4;
  logic         rb_empty, rb_full, rb_re, rb_re4, o_valid, o_valid4;
  logic [7:0]   o_count;
  logic [3:0]   o_count4;

  always #5 clk = ~clk;

  ringbuf #(.WIDTH(W), .SIZE(SIZE)) u_rb (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_wdata(wdata), .i_re(rb_re),
    .o_data(rb_data), .o_empty(rb_empty), .o_full(rb_full)
  );

  ringbuf_reader #(.WIDTH(W), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rb_data(rb_data), .i_rb_empty(rb_empty),
    .o_rb_re(rb_re), .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .i_flush(flush), .o_count(o_count)
  );

  // Same inputs as dut, so it behaves identically apart from the narrower counter.
  ringbuf_reader #(.WIDTH(W), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rb_data(rb_data), .i_rb_empty(rb_empty),
    .o_rb_re(rb_re4), .o_data(o_data4), .o_valid(o_valid4), .i_ready(ready),
    .i_flush(flush), .o_count(o_count4)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int skid_n = 0;
  int delivered = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    int  rb_n;
    bit  exp_re;
    if (!rst_n) begin
      chk(o_valid == 1'b0, "rst_valid", int'(o_valid), 0);
      chk(rb_re == 1'b0, "rst_pop", int'(rb_re), 0);
      chk(o_count == 8'd0, "rst_count", int'(o_count), 0);
      chk(o_data == '0, "rst_data", int'(o_data), 0);
      exp_q.delete();
      skid_n = 0;
      delivered = 0;
    end else begin
      rb_n   = exp_q.size() - skid_n;
      exp_re = (rb_n > 0) && (skid_n < 2) && !flush;
      chk(rb_re == exp_re, "pop", int'(rb_re), int'(exp_re));
      chk(rb_re4 == exp_re, "pop4", int'(rb_re4), int'(exp_re));
      chk(!(rb_re && rb_empty), "pop_on_empty", int'(rb_re && rb_empty), 0);
      chk(o_valid == (skid_n > 0), "valid", int'(o_valid), int'(skid_n > 0));
      chk(o_valid4 == (skid_n > 0), "valid4", int'(o_valid4), int'(skid_n > 0));
      chk(o_count == 8'(delivered), "count", int'(o_count), delivered % 256);
      chk(o_count4 == 4'(delivered), "count4", int'(o_count4), delivered % 16);
      if (skid_n > 0 && ready) begin
        chk(o_data == exp_q[0], "data", int'(o_data), int'(exp_q[0]));
        chk(o_data4 == exp_q[0], "data4", int'(o_data4), int'(exp_q[0]));
        void'(exp_q.pop_front());
        skid_n--;
        delivered++;
      end
      if (flush) begin
        repeat (skid_n) void'(exp_q.pop_front());
        skid_n = 0;
      end
      if (exp_re) skid_n++;
      if (we && rb_n < SIZE) exp_q.push_back(wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // Reset held while a write is attempted; it must not survive release.
    rst_n = 1'b0;
    repeat (2) tick();
    we = 1'b1; wdata = 4'd3;
    tick();
    we = 1'b0;
    tick();
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (10) tick();
    chk(rb_empty == 1'b1, "rst_write_dropped", int'(rb_empty), 1);

    // Streaming at full rate.
    for (int d = 1; d <= 4; d++) begin
      we = 1'b1; wdata = W'(d);
      tick();
    end
    we = 1'b0;
    repeat (6) tick();
    chk(o_count == 8'd4, "stream_count", int'(o_count), 4);

    // Backpressure: skid fills with 5,6 and 7 stays behind.
    ready = 1'b0;
    for (int d = 5; d <= 7; d++) begin
      we = 1'b1; wdata = W'(d);
      tick();
    end
    we = 1'b0;
    repeat (4) tick();
    chk(o_valid && o_data == 4'd5, "bp_head", int'(o_data), 5);
    chk(rb_re == 1'b0, "bp_stall", int'(rb_re), 0);
    chk(rb_empty == 1'b0, "bp_rb_holds", int'(rb_empty), 0);
    ready = 1'b1;
    repeat (6) tick();
    chk(o_count == 8'd7, "bp_count", int'(o_count), 7);

    // Flush a full skid; 10 waits in the ring buffer and comes out next.
    ready = 1'b0;
    for (int d = 8; d <= 9; d++) begin
      we = 1'b1; wdata = W'(d);
      tick();
    end
    we = 1'b0;
    repeat (3) tick();
    we = 1'b1; wdata = 4'd10;
    tick();
    we = 1'b0;
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk(o_valid == 1'b0, "flush_empty", int'(o_valid), 0);
    chk(o_count == 8'd7, "flush_count", int'(o_count), 7);
    ready = 1'b1;
    repeat (4) tick();
    chk(o_count == 8'd8, "flush_next", int'(o_count), 8);

    // Random traffic past the ring wrap point and the 4-bit counter wrap.
    n = 0;
    while (n < 45) begin
      ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        we = 1'b1; wdata = W'($urandom);
        n++;
      end else begin
        we = 1'b0;
      end
      tick();
    end
    we = 1'b0;
    ready = 1'b1;
    repeat (30) tick();
    chk(o_count == 8'd53, "wrap_count", int'(o_count), 53);
    chk(o_count4 == 4'd5, "wrap_count4", int'(o_count4), 5);
    chk(rb_empty && !rb_full && !o_valid, "wrap_drained", int'(o_valid), 0);

    // Asynchronous reset while the skid is full.
    ready = 1'b0;
    for (int d = 11; d <= 13; d++) begin
      we = 1'b1; wdata = W'(d);
      tick();
    end
    we = 1'b0;
    repeat (4) tick();
    chk(o_valid == 1'b1, "pre_reset_two", int'(o_valid), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(o_valid == 1'b0, "async_valid", int'(o_valid), 0);
    chk(o_data == '0, "async_data", int'(o_data), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    ready = 1'b1;
    we = 1'b1; wdata = 4'd14;
    tick();
    we = 1'b0;
    repeat (4) tick();
    chk(o_count == 8'd1, "post_reset_count", int'(o_count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
